cen_gen_multi: RTL and testbench

//  Parametrised multi-channel fractional clock-enable generator for the sim/emu top level.

---
 rtl/cen_gen_multi.sv | 168 ++++++++++++++++
 tb/tb_cen_gen_multi.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cen_gen_multi.sv
// cen_gen_multi: multi-channel fractional clock-enable generator.
// Each channel c emits single-cycle cen[c] pulses at NUM[c]/DEN[c] of clk_sys.
// A first-order accumulator carries the remainder between pulses, which keeps
// the long-run rate exact.
//
// Runtime controls:
//   turbo - doubles the increment on the channels enabled in TURBO_MSK
//   pause - freezes every phase and suppresses all pulses
//   sync  - restarts every phase from zero
// Priority within one cycle is sync > pause > normal.
//
// Optional feature, macro CEN_STATS_EN:
//   Adds a 16-bit pulse counter per channel. stat_cnt reads the counter
//   picked by stat_sel. Without the macro, stat_cnt is tied to zero.
//
// Handshake: none. The outputs are free-running enables. A cen[c] pulse is
// valid for exactly the one clk_sys cycle in which it is high.

module cen_gen_multi #(
    parameter int                          CHANNELS  = 4,
    parameter int                          ACC_W     = 16,
    parameter logic [CHANNELS*ACC_W-1:0]   NUM       = {16'd1, 16'd1, 16'd1, 16'd1},
    parameter logic [CHANNELS*ACC_W-1:0]   DEN       = {16'd12, 16'd4, 16'd2, 16'd4},
    parameter logic [CHANNELS-1:0]         TURBO_MSK = {CHANNELS{1'b1}}
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                pause,
    input  logic                turbo,
    input  logic                sync,
    output logic [CHANNELS-1:0] cen,
    input  logic [2:0]          stat_sel,
    input  logic                stat_clr,
    output logic [15:0]         stat_cnt
);

    // Sums are carried two bits wider than the accumulator so that acc + 2*NUM
    // never truncates.
    localparam int SW = ACC_W + 2;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("cen_gen_multi: CHANNELS must be in 1..8");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chk
        if (DEN[g*ACC_W +: ACC_W] == '0) begin : g_den_zero
            $error("cen_gen_multi: DEN of a channel is zero");
        end
        if (NUM[g*ACC_W +: ACC_W] > DEN[g*ACC_W +: ACC_W]) begin : g_num_big
            $error("cen_gen_multi: NUM of a channel exceeds its DEN");
        end
    end

    // ------------------------------------------------------------------
    // Per-channel ratio lookups, zero-extended to the sum width
    // ------------------------------------------------------------------
    function automatic logic [SW-1:0] num_of(input int c);
        return {2'b00, NUM[c*ACC_W +: ACC_W]};
    endfunction

    function automatic logic [SW-1:0] den_of(input int c);
        return {2'b00, DEN[c*ACC_W +: ACC_W]};
    endfunction

    // ------------------------------------------------------------------
    // Channel state
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]    acc     [CHANNELS];
    logic [ACC_W-1:0]    acc_nxt [CHANNELS];
    logic [SW-1:0]       inc     [CHANNELS];
    logic [SW-1:0]       sum     [CHANNELS];
    logic [CHANNELS-1:0] clamp;
    logic [CHANNELS-1:0] cen_nxt;

    // Next phase and pulse decision for every channel.
    // Order of tests: sync, then pause, then clamp, then the crossing check.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            inc[c]     = (turbo && TURBO_MSK[c]) ? (num_of(c) << 1) : num_of(c);
            sum[c]     = {2'b00, acc[c]} + inc[c];
            clamp[c]   = (inc[c] >= den_of(c));
            acc_nxt[c] = acc[c];
            cen_nxt[c] = 1'b0;

            if (sync) begin
                // Restart the phase. The counters are not touched.
                acc_nxt[c] = '0;
            end else if (pause) begin
                // Hold the phase. It resumes exactly where it was frozen.
                acc_nxt[c] = acc[c];
            end else if (clamp[c]) begin
                // The ratio is at or above 1. Pulse every cycle and drop the
                // remainder so that no overrun builds up.
                acc_nxt[c] = '0;
                cen_nxt[c] = 1'b1;
            end else if (sum[c] >= den_of(c)) begin
                // inc < DEN and acc < DEN, so the remainder fits in ACC_W bits.
                acc_nxt[c] = ACC_W'(sum[c] - den_of(c));
                cen_nxt[c] = 1'b1;
            end else begin
                acc_nxt[c] = sum[c][ACC_W-1:0];
            end
        end
    end

    // Accumulators and the registered enable pulses.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
            cen <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= acc_nxt[c];
            end
            cen <= cen_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Optional pulse statistics
    // ------------------------------------------------------------------
`ifdef CEN_STATS_EN

    logic [15:0] cnt [CHANNELS];

    // Count each registered pulse. A clear wins over a same-cycle increment.
    // The counters wrap from 0xFFFF to 0.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (stat_clr) begin
                    cnt[c] <= '0;
                end else if (cen[c]) begin
                    cnt[c] <= cnt[c] + 16'd1;
                end
            end
        end
    end

    // Combinational read mux. A select beyond the last channel reads zero.
    always_comb begin
        stat_cnt = 16'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (stat_sel == 3'(c)) begin
                stat_cnt = cnt[c];
            end
        end
    end

`else

    // Statistics are not built in this configuration.
    assign stat_cnt = 16'd0;

    wire unused_stat = ^{stat_sel, stat_clr};

`endif

endmodule

// File: tb/tb_cen_gen_multi.sv
// Testbench for cen_gen_multi.
// The DUT is configured with these channel ratios:
//   ch0 = 3/8
//   ch1 = 1/4
//   ch2 = 1/2
//   ch3 = 1/12
// The reference model counts total credit per channel (the sum of increments
// since the last restart). A channel is owed floor(credit/DEN) pulses, and a
// pulse fires whenever that owed count goes up.

module tb_cen_gen_multi;

  localparam int CH = 4;

  logic          clk_sys  = 1'b0;
  logic          reset    = 1'b1;
  logic          pause    = 1'b0;
  logic          turbo    = 1'b0;
  logic          sync     = 1'b0;
  logic          stat_clr = 1'b0;
  logic [2:0]    stat_sel = 3'd0;
  logic [CH-1:0] cen;
  logic [15:0]   stat_cnt;

  cen_gen_multi #(
    .CHANNELS (CH),
    .ACC_W    (16),
    .NUM      ({16'd1, 16'd1, 16'd1, 16'd3}),
    .DEN      ({16'd12, 16'd2, 16'd4, 16'd8}),
    .TURBO_MSK(4'b1111)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .pause   (pause),
    .turbo   (turbo),
    .sync    (sync),
    .cen     (cen),
    .stat_sel(stat_sel),
    .stat_clr(stat_clr),
    .stat_cnt(stat_cnt)
  );

  // ------------------------------------------------------------------
  // Clock
  // ------------------------------------------------------------------
  always #5 clk_sys = ~clk_sys;

  // ------------------------------------------------------------------
  // Reference model state
  // ------------------------------------------------------------------
  int          compared   = 0;
  int          mismatched = 0;
  int          edge_no    = 0;

  int          m_num [CH] = '{3, 1, 1, 1};
  int          m_den [CH] = '{8, 4, 2, 12};
  longint      credit  [CH];
  longint      emitted [CH];
  int          exp_cnt [CH];
  logic [CH-1:0] exp_cen;
  logic [CH-1:0] exp_q[$];

  // ------------------------------------------------------------------
  // Scoreboard compare
  // ------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, exp, edge_no);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      credit[c]  = 0;
      emitted[c] = 0;
      exp_cnt[c] = 0;
    end
    exp_cen = '0;
    edge_no = 0;
  endtask

  // Advance the model by one clock edge.
  task automatic model_step(input bit p, input bit t, input bit s, input bit clr);
    longint inc;
    longint owed;
    logic [CH-1:0] nc;

    // Counters see the pulses that were on the output before this edge.
    for (int c = 0; c < CH; c++) begin
      if (clr)
        exp_cnt[c] = 0;
      else if (exp_cen[c])
        exp_cnt[c] = (exp_cnt[c] + 1) % 65536;
    end

    nc = '0;
    for (int c = 0; c < CH; c++) begin
      if (s) begin
        credit[c]  = 0;
        emitted[c] = 0;
      end else if (!p) begin
        inc = t ? 2 * m_num[c] : m_num[c];
        if (inc >= m_den[c]) begin
          credit[c]  = 0;
          emitted[c] = 0;
          nc[c]      = 1'b1;
        end else begin
          credit[c] += inc;
          owed       = credit[c] / m_den[c];
          nc[c]      = (owed > emitted[c]);
          emitted[c] = owed;
        end
      end
    end

    exp_cen = nc;
    exp_q.push_back(nc);
  endtask

  function automatic logic [15:0] exp_stat(input logic [2:0] sel);
`ifdef CEN_STATS_EN
    if (int'(sel) < CH)
      return 16'(exp_cnt[sel]);
    else
      return 16'd0;
`else
    return (sel == 3'd7) ? 16'd0 : 16'd0;
`endif
  endfunction

  // ------------------------------------------------------------------
  // Driver tasks
  // ------------------------------------------------------------------

  // One clock cycle: drive the inputs, take the edge, then compare the outputs.
  task automatic step(input bit p, input bit t, input bit s, input bit clr, input logic [2:0] sel);
    logic [CH-1:0] e;
    pause    = p;
    turbo    = t;
    sync     = s;
    stat_clr = clr;
    stat_sel = sel;
    @(posedge clk_sys);
    model_step(p, t, s, clr);
    edge_no++;
    #1;
    e = exp_q.pop_front();
    check("cen", 32'(cen), 32'(e));
    check("stat_cnt", 32'(stat_cnt), 32'(exp_stat(sel)));
  endtask

  // Assert reset away from the clock edge, check the reset state, then release.
  task automatic do_reset();
    @(negedge clk_sys);
    reset    = 1'b1;
    pause    = 1'b0;
    turbo    = 1'b0;
    sync     = 1'b0;
    stat_clr = 1'b0;
    #1;
    model_clear();
    check("reset_cen", 32'(cen), 32'd0);
    check("reset_stat", 32'(stat_cnt), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Directed vector table
  // ------------------------------------------------------------------
  typedef struct {
    bit            p;
    bit            t;
    bit            s;
    logic [CH-1:0] exp;
  } vec_t;

  vec_t tbl [19];

  // ------------------------------------------------------------------
  // Test sequence
  // ------------------------------------------------------------------
  initial begin : main
    int n0;
    int n1;
    int n3;
    int last0;
    int maxgap;
    int adj;
    int first1;
    int first3;
    int k;
    bit seen;
    bit tb;
    bit pr;
    bit sy;
    bit cl;
    logic [CH-1:0] prev;

    // Expected cen values per edge after reset release, bits {ch3,ch2,ch1,ch0}.
    tbl[0]  = '{0, 0, 0, 4'b0000};
    tbl[1]  = '{0, 0, 0, 4'b0100};
    tbl[2]  = '{0, 0, 0, 4'b0001};
    tbl[3]  = '{0, 0, 0, 4'b0110};
    tbl[4]  = '{0, 0, 0, 4'b0000};
    tbl[5]  = '{0, 0, 0, 4'b0101};
    tbl[6]  = '{0, 0, 0, 4'b0000};
    tbl[7]  = '{0, 0, 0, 4'b0111};
    tbl[8]  = '{0, 0, 0, 4'b0000};
    tbl[9]  = '{0, 0, 0, 4'b0100};
    tbl[10] = '{0, 0, 0, 4'b0001};
    tbl[11] = '{0, 0, 0, 4'b1110};
    tbl[12] = '{0, 0, 1, 4'b0000};  // sync
    tbl[13] = '{0, 0, 0, 4'b0000};
    tbl[14] = '{0, 0, 0, 4'b0100};
    tbl[15] = '{1, 0, 0, 4'b0000};  // pause
    tbl[16] = '{0, 0, 0, 4'b0001};
    tbl[17] = '{0, 1, 0, 4'b0110};  // turbo: ch2 clamps
    tbl[18] = '{0, 1, 0, 4'b0101};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].p, tbl[i].t, tbl[i].s, 1'b0, 3'd0);
      check("tbl_cen", 32'(cen), 32'(tbl[i].exp));
    end

    // Default rates over 64 cycles: ch1 every 4th edge, ch3 every 12th, ch0 3/8.
    do_reset();
    n0     = 0;
    n1     = 0;
    n3     = 0;
    last0  = 0;
    maxgap = 0;
    adj    = 0;
    prev   = '0;
    for (int j = 1; j <= 64; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      check("ch1_pos", 32'(cen[1]), 32'(j % 4 == 0));
      check("ch3_pos", 32'(cen[3]), 32'(j % 12 == 0));
      if (j <= 48) begin
        n1 += int'(cen[1]);
        n3 += int'(cen[3]);
      end
      if (cen[0]) begin
        n0++;
        if (j - last0 > maxgap)
          maxgap = j - last0;
        last0 = j;
        if (prev[0])
          adj++;
      end
      prev = cen;
    end
    check("ch1_cnt48", 32'(n1), 32'd12);
    check("ch3_cnt48", 32'(n3), 32'd4);
    check("ch0_cnt64", 32'(n0), 32'd24);
    check("ch0_maxgap", 32'(maxgap), 32'd3);
    check("ch0_adjacent", 32'(adj), 32'd0);

    // Turbo from edge 20: ch1 pulses every 2nd edge from edge 20, ch2 pulses every edge.
    do_reset();
    for (int j = 1; j <= 19; j++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    n1 = 0;
    n0 = 0;
    for (int j = 20; j <= 39; j++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      check("turbo_ch1_pos", 32'(cen[1]), 32'(j % 2 == 0));
      n1 += int'(cen[1]);
      n0 += int'(cen[2]);
    end
    check("turbo_ch1_cnt", 32'(n1), 32'd10);
    check("turbo_ch2_clamp", 32'(n0), 32'd20);

    // Pause for 7 cycles after edge 10: no pulses while paused, and the phase resumes.
    do_reset();
    for (int j = 1; j <= 10; j++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    n0 = 0;
    for (int j = 0; j < 7; j++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      n0 += int'(cen != '0);
    end
    check("pause_quiet", 32'(n0), 32'd0);
    first1 = 0;
    for (int j = 18; j <= 30; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      if (cen[1] && first1 == 0)
        first1 = j;
    end
    check("pause_ch1_resume", 32'(first1), 32'd19);

    // Reset asserted in the middle of a pulse clears cen at once.
    do_reset();
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      seen = (cen != '0);
    end
    check("pulse_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_cen", 32'(cen), 32'd0);
    model_clear();
    @(negedge clk_sys);
    reset  = 1'b0;
    first1 = 0;
    first3 = 0;
    for (int j = 1; j <= 12; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      if (cen[1] && first1 == 0)
        first1 = j;
      if (cen[3] && first3 == 0)
        first3 = j;
    end
    check("rst_first_ch1", 32'(first1), 32'd4);
    check("rst_first_ch3", 32'(first3), 32'd12);

    // A sync on the cycle after a ch3 pulse clears cen. ch3 pulses again 12 edges later.
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check("sync_cen", 32'(cen), 32'd0);
    first3 = 0;
    for (int j = 1; j <= 14; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      if (cen[3] && first3 == 0)
        first3 = j;
    end
    check("sync_first_ch3", 32'(first3), 32'd12);

    // Statistics over 1000 cycles of the default ratios.
    do_reset();
    for (int j = 0; j < 1001; j++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    stat_sel = 3'd1;
    #1;
`ifdef CEN_STATS_EN
    check("stat_ch1_1000", 32'(stat_cnt), 32'd250);
    stat_sel = 3'd3;
    #1;
    check("stat_ch3_1000", 32'(stat_cnt), 32'd83);
`else
    check("stat_off_ch1", 32'(stat_cnt), 32'd0);
    stat_sel = 3'd3;
    #1;
    check("stat_off_ch3", 32'(stat_cnt), 32'd0);
`endif
    stat_sel = 3'd5;
    #1;
    check("stat_sel_oob", 32'(stat_cnt), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    stat_sel = 3'd0;
    #1;
    check("stat_after_clr", 32'(stat_cnt), 32'(exp_stat(3'd0)));

    // Randomised run against the model.
    do_reset();
    tb = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 19) == 0)
        tb = ~tb;
      pr = ($urandom_range(0, 9) == 0);
      sy = ($urandom_range(0, 49) == 0);
      cl = ($urandom_range(0, 99) == 0);
      k  = $urandom_range(0, 7);
      step(pr, tb, sy, cl, 3'(k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
